ewma_cov_engine: RTL and testbench

EWMA_COV_ENGINE -- requirements
Module: ewma_cov_engine

---
 rtl/covariance_pkg.sv | 33 +++
 rtl/ewma_mac.sv | 51 +++++
 rtl/ewma_cov_engine.sv | 210 +++++++++++++++++++++
 tb/tb_ewma_cov_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/covariance_pkg.sv
// Shared state type and fixed-point helpers for the
// EWMA covariance engine.
package covariance_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEV,
    COV,
    UPD
  } state_e;

  localparam int MAXW = 128;

  function automatic int unsigned one_q(input int fract);
    return 32'd1 << fract;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_w(
    input logic signed [MAXW-1:0] v,
    input int                     w
  );
    logic signed [MAXW-1:0] unit;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    unit = MAXW'(1);
    hi   = (unit <<< (w - 1)) - unit;
    lo   = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ewma_mac.sv
// Weighted blend (ONE-L)*old + L*term, floor-shifted and
// saturated; one lane per channel, lane 0 doubles as the cov lane.
module ewma_mac
  import covariance_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRACT = 8,
  parameter int LANES = 4
) (
  input  logic [FRACT:0]                 lam,
  input  logic                           cov_mode,
  input  logic [LANES*WIDTH-1:0]         old_in,
  input  logic [LANES*(2*WIDTH+2)-1:0]   term_in,
  output logic [LANES*WIDTH-1:0]         res_out
);

  localparam int TW = 2 * WIDTH + 2;
  localparam int AW = TW + 2 * FRACT + 2;
  localparam logic [FRACT:0] ONE_L = (FRACT + 1)'(one_q(FRACT));

  logic signed [AW-1:0]   o_s;
  logic signed [AW-1:0]   t_s;
  logic signed [AW-1:0]   wo_s;
  logic signed [AW-1:0]   wl_s;
  logic signed [AW-1:0]   acc_s;
  logic signed [AW-1:0]   shd_s;
  logic signed [MAXW-1:0] sat_s;

  always_comb begin
    res_out = '0;
    o_s     = '0;
    t_s     = '0;
    acc_s   = '0;
    shd_s   = '0;
    sat_s   = '0;
    wo_s    = AW'(ONE_L - lam);
    wl_s    = AW'(lam);
    for (int k = 0; k < LANES; k++) begin
      o_s = AW'($signed(old_in[k*WIDTH +: WIDTH]));
      t_s = AW'($signed(term_in[k*TW +: TW]));
      // covariance keeps the old term at the product scale
      if (cov_mode) o_s = o_s <<< FRACT;
      acc_s = wo_s * o_s + wl_s * t_s;
      shd_s = cov_mode ? (acc_s >>> (2 * FRACT))
                       : (acc_s >>> FRACT);
      sat_s = sat_w(MAXW'(shd_s), WIDTH);
      res_out[k*WIDTH +: WIDTH] = WIDTH'(sat_s);
    end
  end

endmodule

// File: rtl/ewma_cov_engine.sv
// Streaming EWMA mean/covariance engine: one upper-triangle
// pair per cycle through a shared weighted MAC.
module ewma_cov_engine
  import covariance_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRACT    = 8,
  parameter int N_STOCKS = 4,
  parameter int WARMUP   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  output logic                                 ready_out,
  input  logic [N_STOCKS*WIDTH-1:0]            x_in,
  input  logic [WIDTH-1:0]                     lambda_in,
  input  logic                                 clear_in,
  output logic                                 valid_out,
  output logic [N_STOCKS*WIDTH-1:0]            mean_out,
  output logic [N_STOCKS*N_STOCKS*WIDTH-1:0]   cov_out,
  output logic                                 warm_out
);

  localparam int NS = N_STOCKS;
  localparam int DW = WIDTH + 1;
  localparam int TW = 2 * DW;
  localparam int LW = FRACT + 1;
  localparam int IW = $clog2(NS);
  localparam int CW = $clog2(WARMUP + 2);
  localparam int unsigned ONE = one_q(FRACT);
  localparam logic [WIDTH:0]  ONE_W  = (WIDTH + 1)'(ONE);
  localparam logic [IW-1:0]   LAST   = IW'(NS - 1);
  localparam logic [CW-1:0]   WARM_C = CW'(WARMUP);

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic                   warm_q, warm_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          i_q, i_d;
  logic [IW-1:0]          j_q, j_d;
  logic [LW-1:0]          lam_q, lam_d;
  logic [NS*WIDTH-1:0]    x_q, x_d;
  logic [NS*WIDTH-1:0]    mean_q, mean_d;
  logic [NS*DW-1:0]       dev_q, dev_d;
  logic [NS*NS*WIDTH-1:0] cov_q, cov_d;
  logic [NS*NS*WIDTH-1:0] covn_q, covn_d;

  logic [LW-1:0]          lam_c;
  logic                   accept;
  logic                   first;
  logic [NS*WIDTH-1:0]    mac_old;
  logic [NS*TW-1:0]       mac_term;
  logic [NS*WIDTH-1:0]    mac_res;
  logic signed [DW-1:0]   di;
  logic signed [DW-1:0]   dj;
  logic signed [TW-1:0]   prod;
  logic [WIDTH-1:0]       cov_new;
  int                     ij;
  int                     ji;

  assign accept = valid_in && ready_q && (state_q == IDLE);
  assign first  = (cnt_q == '0);
  assign lam_c  = ({1'b0, lambda_in} > ONE_W) ? LW'(ONE)
                                              : lambda_in[LW-1:0];

  always_comb begin
    ij      = int'(i_q) * NS + int'(j_q);
    ji      = int'(j_q) * NS + int'(i_q);
    di      = dev_q[int'(i_q)*DW +: DW];
    dj      = dev_q[int'(j_q)*DW +: DW];
    prod    = TW'(di) * TW'(dj);
    cov_new = mac_res[WIDTH-1:0];
    mac_old = mean_q;
    mac_term = '0;
    for (int k = 0; k < NS; k++) begin
      mac_term[k*TW +: TW] = TW'($signed(x_q[k*WIDTH +: WIDTH]));
    end
    // lane 0 carries the current pair while walking the triangle
    if (state_q == COV) begin
      mac_old[WIDTH-1:0] = cov_q[ij*WIDTH +: WIDTH];
      mac_term[TW-1:0]   = prod;
    end
  end

  ewma_mac #(
    .WIDTH (WIDTH),
    .FRACT (FRACT),
    .LANES (NS)
  ) u_mac (
    .lam      (lam_q),
    .cov_mode (state_q == COV),
    .old_in   (mac_old),
    .term_in  (mac_term),
    .res_out  (mac_res)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    warm_d  = warm_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    lam_d   = lam_q;
    x_d     = x_q;
    mean_d  = mean_q;
    dev_d   = dev_q;
    cov_d   = cov_q;
    covn_d  = covn_q;
    if (clear_in) begin
      state_d = IDLE;
      ready_d = 1'b1;
      warm_d  = 1'b0;
      cnt_d   = '0;
      mean_d  = '0;
      cov_d   = '0;
      covn_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (accept) begin
            state_d = DEV;
            ready_d = 1'b0;
            x_d     = x_in;
            lam_d   = lam_c;
          end
        end
        DEV: begin
          for (int k = 0; k < NS; k++) begin
            dev_d[k*DW +: DW] = first ? {DW{1'b0}} :
              DW'($signed(x_q[k*WIDTH +: WIDTH])) -
              DW'($signed(mean_q[k*WIDTH +: WIDTH]));
          end
          i_d     = '0;
          j_d     = '0;
          state_d = COV;
        end
        COV: begin
          covn_d[ij*WIDTH +: WIDTH] = cov_new;
          covn_d[ji*WIDTH +: WIDTH] = cov_new;
          if (j_q == LAST) begin
            if (i_q == LAST) begin
              state_d = UPD;
            end else begin
              i_d = i_q + 1'b1;
              j_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        UPD: begin
          for (int k = 0; k < NS; k++) begin
            mean_d[k*WIDTH +: WIDTH] = first ? x_q[k*WIDTH +: WIDTH]
                                             : mac_res[k*WIDTH +: WIDTH];
          end
          cov_d   = covn_q;
          cnt_d   = (cnt_q < WARM_C) ? cnt_q + 1'b1 : cnt_q;
          warm_d  = (cnt_d >= WARM_C);
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      warm_q  <= 1'b0;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      lam_q   <= '0;
      x_q     <= '0;
      mean_q  <= '0;
      dev_q   <= '0;
      cov_q   <= '0;
      covn_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      lam_q   <= lam_d;
      x_q     <= x_d;
      mean_q  <= mean_d;
      dev_q   <= dev_d;
      cov_q   <= cov_d;
      covn_q  <= covn_d;
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign warm_out  = warm_q;
  assign mean_out  = mean_q;
  assign cov_out   = cov_q;

endmodule

// File: tb/tb_ewma_cov_engine.sv
// Scoreboard bench for ewma_cov_engine: an integer model predicts
// each update, the monitor compares on every valid_out pulse.
module tb_ewma_cov_engine;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [63:0]   x_in = '0;
  logic [15:0]   lambda_in = '0;
  logic          clear_in = 1'b0;
  logic          valid_out;
  logic [63:0]   mean_out;
  logic [255:0]  cov_out;
  logic          warm_out;

  typedef struct {
    logic [63:0]  mean;
    logic [255:0] cov;
    logic         warm;
    int           acc;
  } exp_t;

  exp_t   sb[$];
  bit     wlog[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     acc_cnt = 0;
  int     vcount = 0;
  longint m_mean[4];
  longint m_cov[4][4];
  int     m_cnt;

  ewma_cov_engine #(
    .WIDTH    (16),
    .FRACT    (8),
    .N_STOCKS (4),
    .WARMUP   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x_in      (x_in),
    .lambda_in (lambda_in),
    .clear_in  (clear_in),
    .valid_out (valid_out),
    .mean_out  (mean_out),
    .cov_out   (cov_out),
    .warm_out  (warm_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && valid_in && ready_out) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mean[i] = 0;
      for (int j = 0; j < 4; j++) m_cov[i][j] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [63:0] x, input int lam,
                            input int acc);
    exp_t   e;
    longint l;
    longint xi[4];
    longint d[4];
    longint nc[4][4];
    l = (lam > 256) ? 256 : lam;
    for (int i = 0; i < 4; i++) begin
      xi[i] = longint'($signed(x[i*16 +: 16]));
      d[i]  = (m_cnt == 0) ? 0 : xi[i] - m_mean[i];
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        nc[i][j] = sat16(((256 - l) * m_cov[i][j] * 256
                          + l * d[i] * d[j]) >>> 16);
    for (int i = 0; i < 4; i++)
      m_mean[i] = (m_cnt == 0) ? xi[i]
                : sat16(((256 - l) * m_mean[i] + l * xi[i]) >>> 8);
    m_cov = nc;
    if (m_cnt < 4) m_cnt++;
    for (int i = 0; i < 4; i++) begin
      e.mean[i*16 +: 16] = 16'(m_mean[i]);
      for (int j = 0; j < 4; j++)
        e.cov[(i*4+j)*16 +: 16] = 16'(m_cov[i][j]);
    end
    e.warm = (m_cnt >= 4);
    e.acc  = acc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out) begin
      vcount++;
      wlog.push_back(warm_out);
      if (sb.size() == 0) begin
        chk("sb_empty", 256'(sb.size()), 256'(1));
      end else begin
        e = sb.pop_front();
        chk("sb_mean", 256'(mean_out), 256'(e.mean));
        chk("sb_cov", cov_out, e.cov);
        chk("sb_warm", 256'(warm_out), 256'(e.warm));
        chk("sb_lat", 256'(cyc - e.acc), 256'(12));
      end
    end
  end

  task automatic send(input logic [63:0] x, input int lam,
                      input bit keep, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    x_in = x;
    lambda_in = 16'(lam);
    valid_in = 1'b1;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      chk("send_to", 256'(ready_out), 256'(1));
      valid_in = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      model_push(x, lam, acc);
      @(posedge clk);
      #1;
      if (!keep) valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_to", 256'(sb.size()), 256'(0));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    sb.delete();
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int accs[5];
    int v0;
    int c0;
    int base;
    logic [63:0] bx;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(ready_out), 256'(0));
    chk("rst_valid", 256'(valid_out), 256'(0));
    chk("rst_warm", 256'(warm_out), 256'(0));
    chk("rst_mean", 256'(mean_out), 256'(0));
    chk("rst_cov", cov_out, 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", 256'(ready_out), 256'(1));

    send({4{16'h0100}}, 'h40, 1'b0, a);
    drain();
    chk("s1_mean", 256'(mean_out), 256'({4{16'h0100}}));
    chk("s1_cov", cov_out, 256'(0));
    chk("s1_warm", 256'(warm_out), 256'(0));

    send({4{16'h0200}}, 'h40, 1'b0, a);
    drain();
    chk("s2_mean", 256'(mean_out), 256'({4{16'h0140}}));
    chk("s2_cov", cov_out, {16{16'h0040}});

    pulse_clear();
    send({4{16'h7F00}}, 'h40, 1'b0, a);
    send({4{16'h8000}}, 'h100, 1'b0, a);
    drain();
    chk("sat_mean", 256'(mean_out), 256'({4{16'h8000}}));
    chk("sat_cov", cov_out, {16{16'h7FFF}});

    send({4{16'h0123}}, 'h80, 1'b0, a);
    repeat (4) @(negedge clk);
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    sb.delete();
    model_reset();
    v0 = vcount;
    repeat (20) @(negedge clk);
    chk("clr_novalid", 256'(vcount), 256'(v0));
    chk("clr_mean", 256'(mean_out), 256'(0));
    chk("clr_cov", cov_out, 256'(0));
    chk("clr_warm", 256'(warm_out), 256'(0));
    chk("clr_ready", 256'(ready_out), 256'(1));

    base = wlog.size();
    c0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      bx = {16'(32'h100 + k * 'h30), 16'(-32'h80 + k * 'h20),
            16'(32'h40 * k), 16'(32'h200 - k * 'h50)};
      send(bx, 'h30 + k * 'h20, (k < 4), accs[k]);
    end
    drain();
    for (int k = 1; k < 5; k++)
      chk("bp_gap", 256'(accs[k] - accs[k-1]), 256'(13));
    chk("bp_accepts", 256'(acc_cnt - c0), 256'(5));
    if (wlog.size() >= base + 4) begin
      chk("bp_warm3", 256'(wlog[base+2]), 256'(0));
      chk("bp_warm4", 256'(wlog[base+3]), 256'(1));
    end else begin
      chk("bp_pulses", 256'(wlog.size() - base), 256'(5));
    end

    send({4{16'h0055}}, 'h40, 1'b0, a);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid_mean", 256'(mean_out), 256'(0));
    chk("rmid_cov", cov_out, 256'(0));
    chk("rmid_ready", 256'(ready_out), 256'(0));
    chk("rmid_warm", 256'(warm_out), 256'(0));
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_rel_ready", 256'(ready_out), 256'(1));

    send({4{16'h0100}}, 'h180, 1'b0, a);
    send({4{16'h0300}}, 'h180, 1'b0, a);
    drain();
    chk("clamp_mean", 256'(mean_out), 256'({4{16'h0300}}));
    chk("clamp_cov", cov_out, {16{16'h0400}});

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
